// File: rtl/loop_counter_2d.sv
// Two-level (column inner, row outer) loop counter with start/busy/done handshake.
// Optional stall input enabled by defining LOOP_CNT_STALL_EN.
module loop_counter_2d #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] col_limit,
    input  logic [WIDTH-1:0] row_limit,
`ifdef LOOP_CNT_STALL_EN
    input  logic             stall,
`endif
    output logic [WIDTH-1:0] col_idx,
    output logic [WIDTH-1:0] row_idx,
    output logic             valid,
    output logic             last_col,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned EW = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] col_q, col_d;
    logic [WIDTH-1:0] row_q, row_d;
    logic [WIDTH-1:0] col_lim_q, col_lim_d;
    logic [WIDTH-1:0] row_lim_q, row_lim_d;

    logic [EW-1:0]    col_next_c;
    logic [EW-1:0]    row_next_c;
    logic             row_wrap_c;
    logic             loop_end_c;
    logic             stall_c;

`ifdef LOOP_CNT_STALL_EN
    assign stall_c = stall;
`else
    assign stall_c = 1'b0;
`endif

    // Extra bit keeps the index + STEP sum from wrapping before the limit compare
    assign col_next_c = EW'(col_q) + EW'(STEP);
    assign row_next_c = EW'(row_q) + EW'(1);
    assign row_wrap_c = (col_next_c >= EW'(col_lim_q));
    assign loop_end_c = (row_next_c >= EW'(row_lim_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            col_lim_q <= '0;
            row_lim_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            col_lim_q <= col_lim_d;
            row_lim_q <= row_lim_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        col_lim_d = col_lim_q;
        row_lim_d = row_lim_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    col_lim_d = col_limit;
                    row_lim_d = row_limit;
                    col_d     = '0;
                    row_d     = '0;
                    if ((col_limit != '0) && (row_limit != '0)) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (!stall_c) begin
                    if (row_wrap_c) begin
                        col_d = '0;
                        if (loop_end_c) begin
                            row_d   = '0;
                            state_d = DONE;
                        end else begin
                            row_d = row_next_c[WIDTH-1:0];
                        end
                    end else begin
                        col_d = col_next_c[WIDTH-1:0];
                    end
                end
            end
            DONE: begin
                col_d   = '0;
                row_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign col_idx  = col_q;
    assign row_idx  = row_q;
    assign valid    = (state_q == RUN);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign last_col = valid & row_wrap_c;
    assign last     = last_col & loop_end_c;

endmodule
